// File: rtl/reset_seq_ctrl.sv
// Ordered multi-domain reset sequencer: releases NUM_STAGES resets one at a time,
// each gated by its synchronised ready plus a stable-hold time, and re-asserts on ready loss.
module reset_seq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= sync_d;

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

module reset_seq_ctrl #(
  parameter int NUM_STAGES    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ASSERT_CYCLES = 32,
  parameter int HOLD_CYCLES   = 16,
  parameter logic [NUM_STAGES-1:0] READY_MASK = '1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_STAGES-1:0]             rdy_i,
  input  logic                              sw_rst_i,
  output logic [NUM_STAGES-1:0]             rst_o,
  output logic [NUM_STAGES-1:0]             rst_n_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage_o,
  output logic                              done_o,
  output logic [7:0]                        fault_cnt_o
);
  localparam int SW    = $clog2(NUM_STAGES+1);
  localparam int CMAX  = (ASSERT_CYCLES > HOLD_CYCLES) ? ASSERT_CYCLES : HOLD_CYCLES;
  localparam int CNT_W = $clog2(CMAX+1);

  typedef enum logic [1:0] {ST_ASSERT, ST_WAIT, ST_HOLD, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           k_q, k_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              fcnt_q, fcnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d, rst_n_q;
  logic                    done_q;
  logic [NUM_STAGES-1:0]   rdy_raw, rdy_s;
  logic                    flt, rdy_k;
  logic [SW-1:0]           flt_j;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_sync
    reset_seq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .d_i    (rdy_i[i]),
      .q_o    (rdy_raw[i])
    );
  end

  assign rdy_s = rdy_raw | ~READY_MASK;

  // Descending scan leaves the lowest dropped released stage in flt_j.
  always_comb begin
    flt   = 1'b0;
    flt_j = '0;
    rdy_k = 1'b0;
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      if (SW'(i) < k_q && !rdy_s[i]) begin
        flt   = 1'b1;
        flt_j = SW'(i);
      end
      if (SW'(i) == k_q) rdy_k = rdy_s[i];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    if (sw_rst_i) begin
      state_d = ST_ASSERT;
      k_d     = '0;
      cnt_d   = '0;
    end else if (flt) begin
      state_d = ST_WAIT;
      k_d     = flt_j;
      cnt_d   = '0;
      if (fcnt_q != 8'hff) fcnt_d = fcnt_q + 8'd1;
    end else begin
      case (state_q)
        ST_ASSERT:
          if (cnt_q == CNT_W'(ASSERT_CYCLES-1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        ST_WAIT:
          if (rdy_k) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        ST_HOLD:
          if (!rdy_k) begin
            state_d = ST_WAIT;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES-1)) begin
            k_d     = k_q + 1'b1;
            cnt_d   = '0;
            state_d = (k_q == SW'(NUM_STAGES-1)) ? ST_RUN : ST_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        default: ;
      endcase
    end
  end

  // Stage resets follow k directly: everything at or above the index is held.
  always_comb begin
    rst_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) rst_d[i] = (SW'(i) >= k_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ST_ASSERT;
      k_q     <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      rst_q   <= '1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      rst_q   <= rst_d;
      rst_n_q <= ~rst_d;
      done_q  <= (state_d == ST_RUN);
    end

  assign rst_o       = rst_q;
  assign rst_n_o     = rst_n_q;
  assign stage_o     = k_q;
  assign done_o      = done_q;
  assign fault_cnt_o = fcnt_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: timing vector table, corner-case sequences and a
// randomized run, all checked cycle by cycle against a run-length reference model.
module tb_reset_seq_ctrl;
  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int ASRT = 8;
  localparam int HOLD = 4;
  localparam logic [N-1:0] MASK = 3'b111;
  localparam int SW = $clog2(N+1);

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic          sw_rst_i = 1'b0;
  logic [N-1:0]  rdy_i = 3'b111;
  logic [N-1:0]  rst_o, rst_n_o;
  logic [SW-1:0] stage_o;
  logic          done_o;
  logic [7:0]    fault_cnt_o;

  int checks = 0;
  int failures = 0;

  reset_seq_ctrl #(
    .NUM_STAGES(N), .SYNC_STAGES(SYNC), .ASSERT_CYCLES(ASRT),
    .HOLD_CYCLES(HOLD), .READY_MASK(MASK)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rdy_i(rdy_i), .sw_rst_i(sw_rst_i),
    .rst_o(rst_o), .rst_n_o(rst_n_o), .stage_o(stage_o), .done_o(done_o),
    .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: released-stage count, remaining assert edges, and the
  // run length of consecutive high samples of the current stage's ready.
  int           m_cur, m_left, m_run, m_f;
  logic [N-1:0] m_hist [SYNC];

  task automatic m_reset();
    m_cur = 0; m_left = ASRT; m_run = 0; m_f = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
  endtask

  task automatic m_step();
    logic [N-1:0] rs;
    int j;
    rs = m_hist[SYNC-1] | ~MASK;
    for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = rdy_i;
    if (sw_rst_i) begin
      m_cur = 0; m_left = ASRT; m_run = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      j = -1;
      for (int i = N-1; i >= 0; i--) if (i < m_cur && !rs[i]) j = i;
      if (j >= 0) begin
        m_cur = j; m_run = 0;
        if (m_f < 255) m_f++;
      end else if (m_cur < N) begin
        m_run = rs[m_cur] ? m_run + 1 : 0;
        if (m_run == HOLD + 1) begin m_cur++; m_run = 0; end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [N-1:0] er, ern;
    for (int i = 0; i < N; i++) er[i] = (i >= m_cur);
    ern = ~er;
    chk("model_rst", int'(rst_o), int'(er));
    chk("model_rst_n", int'(rst_n_o), int'(ern));
    chk("model_stage", int'(stage_o), m_cur);
    chk("model_done", int'(done_o), int'(m_cur == N));
    chk("model_fcnt", int'(fault_cnt_o), m_f);
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_i);
      m_step();
      #1;
      chk_model();
    end
  endtask

  task automatic chk_out(input string nm, input logic [N-1:0] r, input int st, input logic d, input int f);
    chk({nm, "_rst"}, int'(rst_o), int'(r));
    chk({nm, "_stage"}, int'(stage_o), st);
    chk({nm, "_done"}, int'(done_o), int'(d));
    chk({nm, "_fcnt"}, int'(fault_cnt_o), f);
  endtask

  typedef struct {
    logic [N-1:0] rdy;
    logic         sw;
    int           n;
    logic [N-1:0] rst;
    int           stage;
    logic         done;
    int           f;
  } vec_t;

  vec_t tv [20];

  initial begin
    tv[0]  = '{3'b111, 1'b0, 12, 3'b111, 0, 1'b0, 0};
    tv[1]  = '{3'b111, 1'b0,  1, 3'b110, 1, 1'b0, 0};
    tv[2]  = '{3'b111, 1'b0,  4, 3'b110, 1, 1'b0, 0};
    tv[3]  = '{3'b111, 1'b0,  1, 3'b100, 2, 1'b0, 0};
    tv[4]  = '{3'b111, 1'b0,  4, 3'b100, 2, 1'b0, 0};
    tv[5]  = '{3'b111, 1'b0,  1, 3'b000, 3, 1'b1, 0};
    tv[6]  = '{3'b101, 1'b0,  2, 3'b000, 3, 1'b1, 0};
    tv[7]  = '{3'b101, 1'b0,  1, 3'b110, 1, 1'b0, 1};
    tv[8]  = '{3'b111, 1'b0,  6, 3'b110, 1, 1'b0, 1};
    tv[9]  = '{3'b111, 1'b0,  1, 3'b100, 2, 1'b0, 1};
    tv[10] = '{3'b111, 1'b0,  4, 3'b100, 2, 1'b0, 1};
    tv[11] = '{3'b111, 1'b0,  1, 3'b000, 3, 1'b1, 1};
    tv[12] = '{3'b010, 1'b0,  2, 3'b000, 3, 1'b1, 1};
    tv[13] = '{3'b010, 1'b0,  1, 3'b111, 0, 1'b0, 2};
    tv[14] = '{3'b001, 1'b1,  1, 3'b111, 0, 1'b0, 2};
    tv[15] = '{3'b001, 1'b0, 12, 3'b111, 0, 1'b0, 2};
    tv[16] = '{3'b001, 1'b0,  1, 3'b110, 1, 1'b0, 2};
    tv[17] = '{3'b001, 1'b0, 17, 3'b110, 1, 1'b0, 2};
    tv[18] = '{3'b011, 1'b0,  6, 3'b110, 1, 1'b0, 2};
    tv[19] = '{3'b011, 1'b0,  1, 3'b100, 2, 1'b0, 2};

    m_reset();
    #2 rst_n_i = 1'b0;
    #1;
    chk("reset_rst_n_o", int'(rst_n_o), 0);
    chk_out("reset", 3'b111, 0, 1'b0, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;

    for (int t = 0; t < 20; t++) begin
      rdy_i = tv[t].rdy;
      sw_rst_i = tv[t].sw;
      step(tv[t].n);
      chk_out($sformatf("vec%0d", t), tv[t].rst, tv[t].stage, tv[t].done, tv[t].f);
    end

    // Ready glitch during stage 2 HOLD: release restarts, no fault counted.
    rdy_i = 3'b111; step(4);
    rdy_i = 3'b011; step(2);
    rdy_i = 3'b111; step(6);
    chk_out("glitch_hold", 3'b100, 2, 1'b0, 2);
    step(1);
    chk_out("glitch_rel", 3'b000, 3, 1'b1, 2);

    // sw_rst_i on the same edge as a fault: restart wins, count unchanged.
    rdy_i = 3'b101; step(2);
    sw_rst_i = 1'b1; step(1);
    chk_out("sw_fault", 3'b111, 0, 1'b0, 2);
    sw_rst_i = 1'b0; rdy_i = 3'b111; step(12);
    chk_out("sw_e12", 3'b111, 0, 1'b0, 2);
    step(1);
    chk_out("sw_e13", 3'b110, 1, 1'b0, 2);

    // Repeated stage-0 loss drives the fault counter into saturation.
    for (int i = 0; i < 300; i++) begin
      rdy_i = 3'b111; step(8);
      rdy_i = 3'b110; step(4);
    end
    chk("sat_fcnt", int'(fault_cnt_o), 255);

    // Asynchronous reset asserted mid-HOLD, between clock edges.
    rdy_i = 3'b111; step(5);
    chk_out("pre_async", 3'b111, 0, 1'b0, 255);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_n_o", int'(rst_n_o), 0);
    chk_out("async", 3'b111, 0, 1'b0, 0);
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;

    // Randomized ready flicker and occasional software restarts.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) rdy_i[$urandom_range(N-1)] ^= 1'b1;
      else if ($urandom_range(7) == 0) rdy_i = 3'b111;
      sw_rst_i = ($urandom_range(199) == 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_seq_ctrl.md
# reset_seq_ctrl

Parametrised multi-stage reset sequencer. It generalises the single-output power-up reset generator and the fixed-depth reset synchroniser into one block. It releases NUM_STAGES ordered reset domains one at a time; each release is gated by that stage's synchronised ready/lock input and a programmable stable-hold time. If a released stage's ready is later lost, it re-asserts that stage and every stage after it. It sits between the clock/transceiver status sources (PLL lock, GT reset-done, TX ready) and the video datapath resets in fpga_top.

## Interface
Parameters:
- NUM_STAGES, 4: number of reset domains (1..16).
- SYNC_STAGES, 2: synchroniser depth on each rdy_i bit (2..5).
- ASSERT_CYCLES, 32: minimum all-asserted time after reset or sw_rst_i (>=1).
- HOLD_CYCLES, 16: cycles a stage's ready must stay high before release (>=1).
- READY_MASK, all ones: bit k=0 means stage k treats its ready as constant 1.

Ports:
- clk_i, in, 1: free-running clock; the only clock.
- rst_n_i, in, 1: asynchronous active-low reset; deassertion is synchronous to clk_i.
- rdy_i, in, NUM_STAGES: per-stage ready/lock; asynchronous to clk_i.
- sw_rst_i, in, 1: synchronous full-restart request, level-sensitive.
- rst_o, out, NUM_STAGES: active-high stage resets.
- rst_n_o, out, NUM_STAGES: exact complement of rst_o.
- stage_o, out, $clog2(NUM_STAGES+1): number of stages currently released (0..NUM_STAGES).
- done_o, out, 1: all stages released.
- fault_cnt_o, out, 8: saturating count of ready-loss events.

## Operation
- Each rdy_i bit passes through SYNC_STAGES ASYNC_REG flops to give rdy_s. Masked bits are forced to 1.
- The state machine uses a stage index k.
- ASSERT: all rst_o=1, k=0. Counts ASSERT_CYCLES, then goes to WAIT. rdy_s is ignored here.
- WAIT: if rdy_s[k]=1, go to HOLD with hold counter = 0.
- HOLD:
  - Counter increments each cycle while rdy_s[k]=1.
  - If rdy_s[k]=0, return to WAIT. No fault is counted and no output changes.
  - At cnt==HOLD_CYCLES-1 with rdy_s[k]=1: clear rst_o[k] and increment k. Go to RUN if k was NUM_STAGES-1, else WAIT.
- RUN: all stages released; done_o=1.
- Fault: in WAIT, HOLD or RUN, let j be the lowest released stage (j<k) with rdy_s[j]=0. On the next edge:
  - set rst_o[j..NUM_STAGES-1]=1;
  - set k=j and go to WAIT;
  - increment fault_cnt_o, saturating at 255.
  - Only one event is counted per cycle, regardless of how many stages dropped.
- Priority: rst_n_i > sw_rst_i > fault > normal progression.
- sw_rst_i=1: go to ASSERT, all rst_o=1, k=0, fault not counted. ASSERT holds while sw_rst_i stays high; the count restarts on its fall.
- A fault and sw_rst_i in the same cycle: sw_rst_i wins, fault_cnt_o unchanged.
- fault_cnt_o clears only on rst_n_i.
- All outputs are registered. stage_o=k, and done_o=(state==RUN).

## Timing
- Reset values: rst_o all 1, rst_n_o all 0, stage_o 0, done_o 0, fault_cnt_o 0. State is ASSERT with its counter at 0; synchroniser flops are 0.
- Numbering: E1 is the first clk_i edge after rst_n_i deasserts.
- ASSERT occupies E1..E_ASSERT_CYCLES; WAIT first evaluates at edge ASSERT_CYCLES+1.
- Release of stage k: rst_o[k] falls HOLD_CYCLES edges after the WAIT edge that saw rdy_s[k]=1. With all ready, stages are spaced HOLD_CYCLES+1 cycles apart.
- rdy_i rise to rst_o[k] fall (stage already in WAIT): SYNC_STAGES + HOLD_CYCLES + 1 cycles.
- rdy_i fall to rst_o[j] rise: SYNC_STAGES + 1 cycles.
- sw_rst_i sampled high: all rst_o=1 on the same edge; restart timing as for reset, counted from sw_rst_i falling.
- A ready pulse shorter than SYNC_STAGES cycles may be missed; no requirement applies.

## Test plan
Default bench parameters: NUM_STAGES=3, SYNC_STAGES=2, ASSERT_CYCLES=8, HOLD_CYCLES=4, READY_MASK=3'b111.
- Power-up, rdy_i=3'b111 held: rst_o[0] falls at E13, rst_o[1] at E18, rst_o[2] at E23; done_o=1 and stage_o=3 at E23; fault_cnt_o=0.
- rdy_i[1] rises at E30 with rdy_i[0]=1: rst_o[1] falls 7 cycles later. Also pulse rdy_i[1] low for 2 cycles mid-HOLD: HOLD restarts, fault_cnt_o unchanged.
- In RUN, drop rdy_i[1]: 3 cycles later rst_o=3'b110, stage_o=1, done_o=0, fault_cnt_o=1. Restore rdy_i[1]: rst_o[1] falls 7 cycles after the rise, then rst_o[2] falls 5 cycles later.
- In RUN, drop rdy_i[0] and rdy_i[2] in the same cycle: rst_o=3'b111, stage_o=0, fault_cnt_o increments by exactly 1.
- sw_rst_i high for 1 cycle coincident with a fault: all rst_o=1, fault_cnt_o unchanged. Re-release follows the power-up timing counted from sw_rst_i falling.
- Toggle rdy_i[0] 300 times in RUN: fault_cnt_o saturates at 255. Then assert rst_n_i mid-HOLD: all outputs return to reset values asynchronously.
